// File: rtl/key_sel_gen.sv
// Debounced push-button stepper driving the 3-bit decoder select (in1 = MSB).
// Optional free-running auto step while the key is idle: define AUTO_STEP_EN.
module key_sel_gen #(
    parameter logic [19:0] CNT_MAX  = 20'd999_999,
    parameter logic [24:0] AUTO_MAX = 25'd24_999_999
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_in,
    output logic in1,
    output logic in2,
    output logic in3,
    output logic sel_flag
);

    localparam int unsigned CNT_W = 20;
    localparam int unsigned SEL_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        P_FILT = 2'd1,
        DOWN   = 2'd2,
        R_FILT = 2'd3
    } state_t;

    logic              sync1;
    logic              key_s;
    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_inc_c;
    logic [SEL_W-1:0]  sel;
    logic              accept_c;
    logic              auto_hit_c;
    logic              step_c;

    // Two-flop synchroniser; resets to the released (high) level
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            sync1 <= 1'b1;
            key_s <= 1'b1;
        end else begin
            sync1 <= key_in;
            key_s <= sync1;
        end
    end

    assign cnt_inc_c = cnt + CNT_W'(1);

    // The IDLE->P_FILT sample counts as the first low sample of the window
    assign accept_c = (state == P_FILT) && !key_s && (cnt_inc_c == CNT_MAX);

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!key_s) begin
                        cnt   <= '0;
                        state <= P_FILT;
                    end
                end
                P_FILT: begin
                    if (key_s) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt_inc_c;
                        if (cnt_inc_c == CNT_MAX) begin
                            state <= DOWN;
                        end
                    end
                end
                DOWN: begin
                    if (key_s) begin
                        cnt   <= '0;
                        state <= R_FILT;
                    end
                end
                R_FILT: begin
                    if (!key_s) begin
                        state <= DOWN;
                    end else begin
                        cnt <= cnt_inc_c;
                        if (cnt_inc_c == CNT_MAX) begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef AUTO_STEP_EN
    localparam int unsigned AUTO_W = 25;

    logic [AUTO_W-1:0] auto_cnt;

    assign auto_hit_c = (state == IDLE) && (auto_cnt == AUTO_MAX);

    // Auto period restarts on any step and whenever the key is not idle
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            auto_cnt <= '0;
        end else if (state != IDLE || step_c) begin
            auto_cnt <= '0;
        end else begin
            auto_cnt <= auto_cnt + AUTO_W'(1);
        end
    end
`else
    assign auto_hit_c = 1'b0;
`endif

    // Acceptance only happens in P_FILT and auto only in IDLE, so one +1 at most
    assign step_c = accept_c | auto_hit_c;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            sel      <= '0;
            sel_flag <= 1'b0;
        end else begin
            sel_flag <= step_c;
            if (step_c) begin
                sel <= sel + SEL_W'(1);
            end
        end
    end

    assign in1 = sel[2];
    assign in2 = sel[1];
    assign in3 = sel[0];

endmodule

// File: tb/tb_key_sel_gen.sv
// Directed bench for key_sel_gen with a short debounce window (CNT_MAX=4, AUTO_MAX=15).
module tb_key_sel_gen;

    logic sys_clk;
    logic sys_rst_n;
    logic key_in;
    logic in1;
    logic in2;
    logic in3;
    logic sel_flag;

    int total = 0;
    int bad   = 0;
    int flag_cnt = 0;

    key_sel_gen #(
        .CNT_MAX (20'd4),
        .AUTO_MAX(25'd15)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .key_in   (key_in),
        .in1      (in1),
        .in2      (in2),
        .in3      (in3),
        .sel_flag (sel_flag)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Pulse counter sampled on the inactive edge
    always @(negedge sys_clk) begin
        if (sel_flag) flag_cnt = flag_cnt + 1;
    end

    typedef struct {
        int low_len;
        int high_len;
        int exp_sel;
        int exp_flags;
    } vec_t;

    vec_t vecs[6];

    function automatic int sel_now();
        return int'({in1, in2, in3});
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic press(input int lo, input int hi);
        key_in = 1'b0;
        repeat (lo) tick();
        key_in = 1'b1;
        repeat (hi) tick();
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        key_in    = 1'b1;
        repeat (3) tick();
        sys_rst_n = 1'b1;
    endtask

    initial begin
        int f0;
        sys_rst_n = 1'b0;
        key_in    = 1'b1;

        do_reset();
        chk("reset_sel", sel_now(), 0);
        chk("reset_flag", int'(sel_flag), 0);

`ifdef AUTO_STEP_EN
        // Auto stepping from reset release: first step at cycle 16, second at 32
        repeat (15) tick();
        chk("auto_pre16", sel_now(), 0);
        tick();
        chk("auto_at16_sel", sel_now(), 1);
        chk("auto_at16_flag", int'(sel_flag), 1);
        repeat (15) tick();
        chk("auto_pre32", sel_now(), 1);
        tick();
        chk("auto_at32_sel", sel_now(), 2);
        // Held key: one accepted step, then no auto stepping
        f0 = flag_cnt;
        key_in = 1'b0;
        repeat (60) tick();
        chk("auto_hold_sel", sel_now(), 3);
        chk("auto_hold_flags", flag_cnt - f0, 1);
        key_in = 1'b1;
        tick();
`else
        repeat (2) tick();

        // Clean press: step lands 2+5 cycles after the fall
        f0 = flag_cnt;
        key_in = 1'b0;
        repeat (6) tick();
        chk("lat_pre_sel", sel_now(), 0);
        chk("lat_pre_flag", int'(sel_flag), 0);
        tick();
        chk("lat_sel", sel_now(), 1);
        chk("lat_flag", int'(sel_flag), 1);
        tick();
        chk("lat_flag_one_cycle", int'(sel_flag), 0);
        repeat (13) tick();
        key_in = 1'b1;
        repeat (20) tick();
        chk("lat_flags", flag_cnt - f0, 1);

        vecs[0] = '{20,  20, 2, 1};
        vecs[1] = '{3,   20, 2, 0};
        vecs[2] = '{4,   20, 2, 0};
        vecs[3] = '{5,   20, 3, 1};
        vecs[4] = '{100, 20, 4, 1};
        vecs[5] = '{20,  20, 5, 1};
        for (int i = 0; i < 6; i++) begin
            f0 = flag_cnt;
            press(vecs[i].low_len, vecs[i].high_len);
            chk($sformatf("vec%0d_sel", i), sel_now(), vecs[i].exp_sel);
            chk($sformatf("vec%0d_flags", i), flag_cnt - f0, vecs[i].exp_flags);
        end

        // Press bounce: 3 low, 1 high, 3 low
        f0 = flag_cnt;
        press(3, 1);
        press(3, 20);
        chk("bounce_sel", sel_now(), 5);
        chk("bounce_flags", flag_cnt - f0, 0);

        // Release bounce: interrupted release filter must not re-trigger
        f0 = flag_cnt;
        press(20, 2);
        press(2, 20);
        chk("rel_bounce_sel", sel_now(), 6);
        chk("rel_bounce_flags", flag_cnt - f0, 1);

        // Wrap through all eight codes from reset
        do_reset();
        f0 = flag_cnt;
        for (int i = 0; i < 8; i++) begin
            press(10, 10);
            chk($sformatf("wrap%0d_sel", i), sel_now(), (i + 1) % 8);
        end
        chk("wrap_flags", flag_cnt - f0, 8);

        // Reset while in P_FILT discards the press
        press(20, 20);
        chk("prereset_sel", sel_now(), 1);
        key_in = 1'b0;
        repeat (4) tick();
        f0 = flag_cnt;
        sys_rst_n = 1'b0;
        key_in    = 1'b1;
        repeat (3) tick();
        chk("midreset_sel", sel_now(), 0);
        sys_rst_n = 1'b1;
        repeat (20) tick();
        chk("postreset_sel", sel_now(), 0);
        chk("postreset_flags", flag_cnt - f0, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
